gnn_0_example_rd_arbiter: RTL and testbench
===========================================

Name: gnn_0_example_rd_arbiter

Overview:
- Shares the single AXI read master (read-ctrl port plus receive stream) between NUM_REQ loader blocks: bias, weight and feature loaders.
- Each requester posts an (address, size) transfer request. The arbiter grants requests round-robin, issues one read_start per grant and holds the grant until read_done.
- While a grant is held, the returned data stream is steered to the granted requester only.
- Sits between the per-kernel load modules and the AXI read master stage.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- C_M_AXI_ADDR_WIDTH, 64, DRAM byte address width.
- C_M_AXI_DATA_WIDTH, 512, stream data width.
- C_XFER_SIZE_WIDTH, 32, transfer size field width, in bytes.

Ports:
- kernel_clk  in  1  clock.
- kernel_rst  in  1  reset, asynchronous, active-high.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  base offset added to every request address.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-cycle accept pulse for the granted requester.
- req_addr  in  NUM_REQ*C_M_AXI_ADDR_WIDTH  packed byte addresses; requester i uses slice i.
- req_size  in  NUM_REQ*C_XFER_SIZE_WIDTH  packed byte sizes.
- req_done  out  NUM_REQ  one-cycle completion pulse.
- dram_xfer_start_addr  out  C_M_AXI_ADDR_WIDTH  to the read master.
- dram_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  to the read master.
- read_start  out  1  one-cycle start pulse.
- read_done  in  1  read master completion pulse.
- data_tvalid  in  1  stream from the read master.
- data_tready  out  1  stream from the read master.
- data_tlast  in  1  stream from the read master.
- data_tdata  in  C_M_AXI_DATA_WIDTH  stream from the read master.
- rd_tvalid  out  NUM_REQ  per-requester steered valid.
- rd_tready  in  NUM_REQ  per-requester ready.
- rd_tlast  out  1  broadcast last.
- rd_tdata  out  C_M_AXI_DATA_WIDTH  broadcast data.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all registered outputs 0, state IDLE, priority pointer 0, grant index 0. Reset mid-transfer aborts immediately; no req_done is issued for the aborted grant.
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from the priority pointer, wrapping modulo NUM_REQ.
  - Register grant index g, addr = req_addr[g] + ctrl_addr_offset (wraps modulo 2^ADDR), and size = req_size[g].
  - Transition to ISSUE.
- ISSUE (1 cycle):
  - read_start = 1 and req_ready[g] = 1.
  - dram_xfer_start_addr and dram_xfer_size_in_bytes are valid this cycle and held until DONE.
  - If size == 0: no read_start, go directly to DONE.
  - Otherwise go to BUSY.
- BUSY: wait for read_done, then go to DONE. read_done is also honoured if it arrives during the ISSUE cycle.
- DONE (1 cycle):
  - req_done[g] = 1.
  - Priority pointer = (g+1) mod NUM_REQ.
  - Transition to IDLE.
- Latency and throughput:
  - req_valid seen in IDLE at cycle t gives read_start at t+1.
  - read_done at cycle u gives req_done at u+1.
  - A next grant is possible with read_start at u+3.
- Requester obligation: hold req_valid, req_addr and req_size stable until req_ready. Deasserting before the grant withdraws the request.
- Stream steering, combinational:
  - In ISSUE or BUSY: rd_tvalid[g] = data_tvalid, data_tready = rd_tready[g], all other rd_tvalid = 0.
  - In IDLE or DONE: data_tready = 0 and all rd_tvalid = 0.
  - rd_tdata and rd_tlast follow data_tdata and data_tlast at all times.
- A new req_valid during BUSY is not granted until the FSM returns to IDLE. A simultaneous request from the current grantee is deprioritised by the pointer update.
- Only one outstanding transfer at any time.

Optional Feature:
- Macro: RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the priority pointer is forced to 0 and never updated.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: req_valid = 001, addr 0x1000, size 128, offset 0x40.
  - read_start one cycle later, with dram_xfer_start_addr = 0x1040 and size = 128.
  - Mem model returns 2 beats; rd_tvalid[0] pulses twice and rd_tvalid[1..2] stay 0.
  - read_done triggers req_done[0] one cycle later.
- All three request continuously, size 64 each:
  - Grant order 0,1,2,0,1,2 (round-robin).
  - With RD_ARB_FIXED_PRIO_EN: grant order 0,0,0 while req 0 is held.
- Zero-size request on req 1:
  - req_ready[1] pulses, no read_start is issued.
  - req_done[1] pulses 2 cycles after the grant; data_tready stays 0 throughout.
- Backpressure: rd_tready[2] = 0 for 5 cycles during a 4-beat transfer to req 2.
  - data_tready = 0 during the stall; all 4 beats delivered in order with no loss.
- Reset asserted in BUSY:
  - busy = 0, read_start = 0 and req_done = 0 immediately.
  - A subsequent request on req 0 is granted normally.
- Request withdrawn: req_valid[1] pulses for 1 cycle while busy serving req 0.
  - No grant is issued to req 1; arbiter returns to IDLE after req_done[0].

Source files
------------

// File: rtl/gnn_0_example_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master between NUM_REQ loaders.
// Define RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module gnn_0_example_rd_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                               kernel_clk,
    input  logic                               kernel_rst,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]  req_size,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      dram_xfer_start_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]       dram_xfer_size_in_bytes,
    output logic                               read_start,
    input  logic                               read_done,
    input  logic                               data_tvalid,
    output logic                               data_tready,
    input  logic                               data_tlast,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      data_tdata,
    output logic [NUM_REQ-1:0]                 rd_tvalid,
    input  logic [NUM_REQ-1:0]                 rd_tready,
    output logic                               rd_tlast,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      rd_tdata,
    output logic                               busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t                          state, state_next;
    logic [IW-1:0]                   grant;
    logic [IW-1:0]                   ptr;
    logic [IW-1:0]                   pick;
    logic                            pick_valid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
    logic [C_XFER_SIZE_WIDTH-1:0]    size;

    // First requester at or above the priority pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!pick_valid && req_valid[idx]) begin
                pick       = IW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            addr  <= '0;
            size  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick_valid) begin
                grant <= pick;
                addr  <= req_addr[pick*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH] + ctrl_addr_offset;
                size  <= req_size[pick*C_XFER_SIZE_WIDTH +: C_XFER_SIZE_WIDTH];
            end
`ifdef RD_ARB_FIXED_PRIO_EN
            ptr <= '0;
`else
            if (state == DONE)
                ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        read_start  = 1'b0;
        req_ready   = '0;
        req_done    = '0;
        data_tready = 1'b0;
        rd_tvalid   = '0;
        case (state)
            IDLE: begin
                if (pick_valid)
                    state_next = ISSUE;
            end
            ISSUE: begin
                req_ready[grant] = 1'b1;
                // A zero-byte grant never touches the read master or the stream.
                if (size == '0) begin
                    state_next = DONE;
                end else begin
                    read_start       = 1'b1;
                    rd_tvalid[grant] = data_tvalid;
                    data_tready      = rd_tready[grant];
                    state_next       = read_done ? DONE : BUSY;
                end
            end
            BUSY: begin
                rd_tvalid[grant] = data_tvalid;
                data_tready      = rd_tready[grant];
                if (read_done)
                    state_next = DONE;
            end
            DONE: begin
                req_done[grant] = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dram_xfer_start_addr    = addr;
    assign dram_xfer_size_in_bytes = size;
    assign rd_tdata                = data_tdata;
    assign rd_tlast                = data_tlast;
    assign busy                    = (state != IDLE);

endmodule

// File: tb/tb_gnn_0_example_rd_arbiter.sv
// Directed bench for gnn_0_example_rd_arbiter: grant and beat scoreboards.
module tb_gnn_0_example_rd_arbiter;

    localparam int NR = 3;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  off;
    logic [NR-1:0]  req_valid, req_ready, req_done, rd_tvalid, rd_tready;
    logic [AW-1:0]  a [NR];
    logic [SW-1:0]  s [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*SW-1:0] req_size;
    logic [AW-1:0]  dram_xfer_start_addr;
    logic [SW-1:0]  dram_xfer_size_in_bytes;
    logic           read_start, read_done, data_tvalid, data_tready, data_tlast;
    logic [DW-1:0]  data_tdata, rd_tdata;
    logic           rd_tlast, busy;

    int tests = 0;
    int fails = 0;
    int grant_q[$];
    logic [DW:0] beat_q[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NR; i++) begin : g_pack
        assign req_addr[i*AW +: AW] = a[i];
        assign req_size[i*SW +: SW] = s[i];
    end

    gnn_0_example_rd_arbiter #(
        .NUM_REQ(NR), .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(SW)
    ) dut (
        .kernel_clk(clk), .kernel_rst(rst), .ctrl_addr_offset(off),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_done(req_done),
        .dram_xfer_start_addr(dram_xfer_start_addr),
        .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
        .read_start(read_start), .read_done(read_done),
        .data_tvalid(data_tvalid), .data_tready(data_tready),
        .data_tlast(data_tlast), .data_tdata(data_tdata),
        .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
        .rd_tlast(rd_tlast), .rd_tdata(rd_tdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pop_grant();
        if (grant_q.size() == 0) return 0;
        return grant_q.pop_front();
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Called in the IDLE cycle where the request is posted; returns in ISSUE.
    task automatic issue_phase(input int g, input logic [SW-1:0] sz);
        step();
        chk("issue_read_start", DW'(read_start), DW'(sz != '0));
        chk("issue_req_ready", DW'(req_ready), DW'(onehot(g)));
        chk("issue_addr", DW'(dram_xfer_start_addr), DW'(a[g] + off));
        chk("issue_size", DW'(dram_xfer_size_in_bytes), DW'(sz));
        chk("issue_busy", DW'(busy), DW'(1'b1));
        chk("issue_req_done", DW'(req_done), DW'(0));
    endtask

    // Streams beats with an rd_tready stall window, then pulses read_done; returns in DONE.
    task automatic busy_phase(input int g, input int beats, input int st, input int sl);
        int   sent = 0;
        int   cyc = 0;
        bit   pending = 0;
        logic [DW:0] e;
        step();
        chk("busy_busy", DW'(busy), DW'(1'b1));
        chk("busy_read_start", DW'(read_start), DW'(0));
        chk("busy_req_ready", DW'(req_ready), DW'(0));
        while (sent < beats && cyc < 64) begin
            if (!pending) begin
                for (int k = 0; k < DW / 32; k++) data_tdata[k*32 +: 32] = $urandom;
                data_tlast  = (sent == beats - 1);
                data_tvalid = 1'b1;
                beat_q.push_back({data_tlast, data_tdata});
                pending = 1;
            end
            rd_tready[g] = !(cyc >= st && cyc < st + sl);
            #1;
            chk("steer_tvalid", DW'(rd_tvalid), DW'(onehot(g)));
            chk("steer_tready", DW'(data_tready), DW'(rd_tready[g]));
            if (rd_tvalid[g] && rd_tready[g]) begin
                e = beat_q.pop_front();
                chk("beat_data", rd_tdata, e[DW-1:0]);
                chk("beat_last", DW'(rd_tlast), DW'(e[DW]));
                sent++;
                pending = 0;
            end
            step();
            cyc++;
        end
        chk("beats_delivered", DW'(sent), DW'(beats));
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
        rd_tready   = '1;
        #1;
        chk("busy_no_tvalid", DW'(rd_tvalid), DW'(0));
        read_done = 1'b1;
        step();
        read_done = 1'b0;
    endtask

    // Entered in DONE; returns in the following IDLE cycle.
    task automatic done_phase(input int g);
        chk("done_req_done", DW'(req_done), DW'(onehot(g)));
        chk("done_read_start", DW'(read_start), DW'(0));
        chk("done_busy", DW'(busy), DW'(1'b1));
        data_tvalid = 1'b1;
        #1;
        chk("done_tvalid", DW'(rd_tvalid), DW'(0));
        chk("done_tready", DW'(data_tready), DW'(0));
        data_tvalid = 1'b0;
        step();
        chk("idle_busy", DW'(busy), DW'(0));
        chk("idle_req_done", DW'(req_done), DW'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int g;
        off         = '0;
        req_valid   = '0;
        read_done   = 1'b0;
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
        data_tdata  = '0;
        rd_tready   = '1;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            s[i] = '0;
        end
        step();
        step();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_read_start", DW'(read_start), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_req_done", DW'(req_done), DW'(0));
        chk("rst_data_tready", DW'(data_tready), DW'(0));
        chk("rst_addr", DW'(dram_xfer_start_addr), DW'(0));
        chk("rst_size", DW'(dram_xfer_size_in_bytes), DW'(0));
        rst = 1'b0;

        // Single request with offset
        off = 64'h40; a[0] = 64'h1000; s[0] = 32'd128;
        req_valid = 3'b001; grant_q.push_back(0);
        g = pop_grant();
        issue_phase(g, 32'd128);
        chk("t1_addr_const", DW'(dram_xfer_start_addr), DW'(64'h1040));
        req_valid = '0;
        busy_phase(g, 2, 99, 0);
        done_phase(g);

        // All three requesting continuously
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a[i] = 64'h2000 + 64'(i) * 64'h100;
            s[i] = 32'd64;
        end
`ifdef RD_ARB_FIXED_PRIO_EN
        for (int n = 0; n < 6; n++) grant_q.push_back(0);
`else
        for (int n = 0; n < 6; n++) grant_q.push_back(n % NR);
`endif
        req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            g = pop_grant();
            issue_phase(g, 32'd64);
            if (n == 5) begin
                read_done = 1'b1;
                step();
                read_done = 1'b0;
            end else begin
                busy_phase(g, 1, 99, 0);
            end
            done_phase(g);
        end
        req_valid = '0;
        step();
        chk("rr_quiet_busy", DW'(busy), DW'(0));

        // Zero-size request on req 1
        a[1] = 64'h3000; s[1] = '0;
        req_valid = 3'b010; grant_q.push_back(1);
        g = pop_grant();
        issue_phase(g, '0);
        req_valid = '0;
        #1;
        chk("zero_data_tready", DW'(data_tready), DW'(0));
        step();
        done_phase(g);

        // Backpressure on req 2
        a[2] = 64'h4000; s[2] = 32'd256;
        req_valid = 3'b100; grant_q.push_back(2);
        g = pop_grant();
        issue_phase(g, 32'd256);
        req_valid = '0;
        busy_phase(g, 4, 1, 5);
        done_phase(g);

        // Reset while BUSY
        a[0] = 64'h5000; s[0] = 32'd64;
        req_valid = 3'b001; grant_q.push_back(0);
        g = pop_grant();
        issue_phase(g, 32'd64);
        req_valid = '0;
        step();
        chk("rstb_busy_before", DW'(busy), DW'(1'b1));
        rst = 1'b1;
        #1;
        chk("rstb_busy", DW'(busy), DW'(0));
        chk("rstb_read_start", DW'(read_start), DW'(0));
        chk("rstb_req_done", DW'(req_done), DW'(0));
        step();
        rst = 1'b0;
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        chk("rstb_no_req_done", DW'(req_done), DW'(0));
        chk("rstb_idle", DW'(busy), DW'(0));
        req_valid = 3'b001; grant_q.push_back(0);
        g = pop_grant();
        issue_phase(g, 32'd64);
        req_valid = '0;
        busy_phase(g, 1, 99, 0);
        done_phase(g);

        // Withdrawn request on req 1 while serving req 0
        a[0] = 64'h6000;
        req_valid = 3'b001; grant_q.push_back(0);
        g = pop_grant();
        issue_phase(g, 32'd64);
        req_valid = '0;
        step();
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        chk("wd_busy", DW'(busy), DW'(1'b1));
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        done_phase(g);
        for (int n = 0; n < 2; n++) begin
            step();
            chk("wd_read_start", DW'(read_start), DW'(0));
            chk("wd_req_ready", DW'(req_ready), DW'(0));
            chk("wd_busy_idle", DW'(busy), DW'(0));
        end
        chk("grant_q_empty", DW'(grant_q.size()), DW'(0));
        chk("beat_q_empty", DW'(beat_q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
